// File: rtl/eq_gain_ramp_scheduler_pkg.sv
// Shared constants, gain type and FSM state encoding for the EQ gain ramp scheduler.
package eq_gain_pkg;

    localparam int N_BANDS = 10;
    localparam int GAIN_W  = 13;

    typedef logic [GAIN_W-1:0] gain_t;

    // Unity in unsigned Q2.11.
    localparam gain_t UNITY_GAIN = 13'd2048;

    // Index of the final band visited during a scan pass.
    localparam logic [3:0] LAST_IDX = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/eq_gain_ramp_scheduler_if.sv
// Bundle of control, target and applied-gain signals between the register map,
// the scheduler and the equalizer datapath.
interface eq_gain_ramp_scheduler_if;
    import eq_gain_pkg::*;

    logic                        enable;
    logic                        sample_tick;
    logic [N_BANDS*GAIN_W-1:0]   target_gains;
    logic [N_BANDS*GAIN_W-1:0]   applied_gains;
    logic                        gains_valid;
    logic                        busy;
    logic                        settled;
    logic                        tick_overrun;

    modport master (
        output enable, sample_tick, target_gains,
        input  applied_gains, gains_valid, busy, settled, tick_overrun
    );

    modport slave (
        input  enable, sample_tick, target_gains,
        output applied_gains, gains_valid, busy, settled, tick_overrun
    );

endinterface

// File: rtl/eq_gain_ramp_scheduler_step_unit.sv
// Shared stepper: moves one gain toward its target by at most STEP, never
// overshooting and never wrapping.
module eq_gain_step_unit
    import eq_gain_pkg::*;
#(
    parameter int STEP = 16
) (
    input  gain_t current_gain,
    input  gain_t target_gain,
    output gain_t next_gain
);

    localparam logic [GAIN_W:0] STEP_X = (GAIN_W+1)'(STEP);
    localparam gain_t           STEP_G = GAIN_W'(STEP);

    logic [GAIN_W:0] diff_s;
    logic            neg_s;
    logic [GAIN_W:0] mag_s;

    // Widen by one bit so the difference carries its sign, then clamp the move to STEP.
    always_comb begin
        diff_s = {1'b0, target_gain} - {1'b0, current_gain};
        neg_s  = diff_s[GAIN_W];
        if (neg_s) begin
            mag_s = (~diff_s) + {{GAIN_W{1'b0}}, 1'b1};
        end else begin
            mag_s = diff_s;
        end
        if (mag_s <= STEP_X) begin
            next_gain = target_gain;
        end else if (!neg_s) begin
            next_gain = current_gain + STEP_G;
        end else begin
            next_gain = current_gain - STEP_G;
        end
    end

endmodule

// File: rtl/eq_gain_ramp_scheduler.sv
// Snapshots the 10 target gains on an accepted sample tick, walks the bands
// serially through one stepper, then commits all applied gains at once.
module eq_gain_ramp_scheduler
    import eq_gain_pkg::*;
#(
    parameter int    STEP       = 16,
    parameter gain_t RESET_GAIN = UNITY_GAIN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    eq_gain_ramp_scheduler_if.slave     bus
);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] idx_r;
    gain_t      snap_r    [N_BANDS];
    gain_t      work_r    [N_BANDS];
    gain_t      applied_r [N_BANDS];
    logic       unsettled_r;
    logic       gains_valid_r;
    logic       busy_r;
    logic       settled_r;
    logic       overrun_r;

    logic       tick_s;
    logic       accept_s;
    logic       drop_s;
    logic       scan_s;
    logic       commit_s;
    gain_t      cur_s;
    gain_t      tgt_s;
    gain_t      step_s;

    assign tick_s   = bus.sample_tick & bus.enable;
    assign scan_s   = (state_r == SCAN);
    assign commit_s = (state_r == COMMIT);
    assign cur_s    = applied_r[idx_r];
    assign tgt_s    = snap_r[idx_r];

    eq_gain_step_unit #(.STEP(STEP)) u_step (
        .current_gain (cur_s),
        .target_gain  (tgt_s),
        .next_gain    (step_s)
    );

    // Next-state logic; enabled ticks outside IDLE (including COMMIT) are dropped.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    accept_s = 1'b1;
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                drop_s = tick_s;
                if (idx_r == LAST_IDX) begin
                    state_s = COMMIT;
                end else begin
                    state_s = SCAN;
                end
            end
            COMMIT: begin
                drop_s  = tick_s;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Band index advances once per SCAN cycle and parks at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 4'd0;
        end else if (scan_s && (idx_r != LAST_IDX)) begin
            idx_r <= idx_r + 4'd1;
        end else begin
            idx_r <= 4'd0;
        end
    end

    // Snapshot of the targets, frozen for the whole pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANDS; i++) snap_r[i] <= RESET_GAIN;
        end else if (accept_s) begin
            for (int i = 0; i < N_BANDS; i++) snap_r[i] <= bus.target_gains[i*GAIN_W +: GAIN_W];
        end else begin
            for (int i = 0; i < N_BANDS; i++) snap_r[i] <= snap_r[i];
        end
    end

    // Stepped gains accumulate here so the datapath never sees a partial set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANDS; i++) work_r[i] <= RESET_GAIN;
        end else if (scan_s) begin
            work_r[idx_r] <= step_s;
        end else begin
            for (int i = 0; i < N_BANDS; i++) work_r[i] <= work_r[i];
        end
    end

    // Tracks whether any band in this pass still differs from its snapshot target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unsettled_r <= 1'b0;
        end else if (accept_s) begin
            unsettled_r <= 1'b0;
        end else if (scan_s && (step_s != tgt_s)) begin
            unsettled_r <= 1'b1;
        end else begin
            unsettled_r <= unsettled_r;
        end
    end

    // Atomic commit of all applied gains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANDS; i++) applied_r[i] <= RESET_GAIN;
        end else if (commit_s) begin
            for (int i = 0; i < N_BANDS; i++) applied_r[i] <= work_r[i];
        end else begin
            for (int i = 0; i < N_BANDS; i++) applied_r[i] <= applied_r[i];
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gains_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            settled_r     <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            gains_valid_r <= commit_s;
            busy_r        <= (state_s != IDLE);
            settled_r     <= commit_s ? ~unsettled_r : settled_r;
            overrun_r     <= drop_s;
        end
    end

    for (genvar g = 0; g < N_BANDS; g++) begin : g_pack
        assign bus.applied_gains[g*GAIN_W +: GAIN_W] = applied_r[g];
    end

    assign bus.gains_valid  = gains_valid_r;
    assign bus.busy         = busy_r;
    assign bus.settled      = settled_r;
    assign bus.tick_overrun = overrun_r;

endmodule

// File: doc/eq_gain_ramp_scheduler.md
Name: eq_gain_ramp_scheduler

Overview:
Sits between the I2C register map and the 10-band equalizer datapath. It captures the 10 target gains once per audio sample tick, then steps each band's applied gain toward its target by at most STEP. Bands are processed serially through one shared step unit. All 10 applied gains commit atomically, so the datapath never sees a torn gain set and abrupt I2C writes do not cause zipper noise.

Parameters:
N_BANDS, 10, number of equalizer bands (fixed at 10 for this revision)
GAIN_W, 13, gain width; unsigned Q2.11
STEP, 16, maximum change per band per tick; must be >= 1 and < 2^GAIN_W
RESET_GAIN, 13'd2048, applied gain after reset (unity)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  when low, new ticks are ignored
sample_tick  in  1  one-cycle pulse per audio sample
target_gains  in  N_BANDS*GAIN_W  reg_map gains packed; band 1 = bits [12:0], band k = bits [13k-1:13(k-1)]
applied_gains  out  N_BANDS*GAIN_W  gains to the datapath, same packing
gains_valid  out  1  one-cycle pulse when applied_gains has just been updated
busy  out  1  high while a pass is in progress (SCAN or COMMIT)
settled  out  1  high when every applied gain equals its snapshot target
tick_overrun  out  1  one-cycle pulse when a tick is dropped because busy

Behaviour:
- Clock domain and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (asynchronous, immediate):
  - applied_gains = all bands RESET_GAIN.
  - Work and snapshot arrays = RESET_GAIN.
  - gains_valid = 0, busy = 0, settled = 0, tick_overrun = 0.
  - State = IDLE, band index = 0.
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - When sample_tick && enable: copy target_gains into the snapshot register and go to SCAN with idx = 0.
  - Otherwise stay in IDLE.
- SCAN (one band per cycle):
  - diff = snapshot[idx] - applied[idx], evaluated as GAIN_W+1-bit signed.
  - If |diff| <= STEP: work[idx] = snapshot[idx].
  - Else if diff > 0: work[idx] = applied[idx] + STEP.
  - Else: work[idx] = applied[idx] - STEP.
  - No wrap and no overshoot is possible; the result always lies between applied[idx] and snapshot[idx].
  - Record per pass whether work != snapshot for any band (the "unsettled" flag).
  - idx increments each cycle; after idx = N_BANDS-1, go to COMMIT.
- COMMIT (one cycle):
  - applied_gains <= work.
  - gains_valid pulses in the following cycle.
  - settled <= !unsettled.
  - Go to IDLE.
- Latency: tick accepted in cycle T.
  - SCAN occupies T+1..T+10.
  - COMMIT occurs at T+11.
  - New applied_gains and gains_valid = 1 are visible at T+12.
  - busy is high T+1..T+11.
  - Minimum tick spacing is 12 cycles.
- Tick while busy: the tick is dropped, tick_overrun pulses the next cycle, and the pass continues unaffected.
- Tick in the same cycle as COMMIT counts as busy and is dropped.
- target_gains changes after the snapshot are ignored until the next accepted tick.
- enable falling mid-pass: the pass completes normally; later ticks are ignored and tick_overrun stays 0.
- applied_gains is held constant between commits.

Decomposition:
- Package eq_gain_pkg holds:
  - Constants N_BANDS = 10, GAIN_W = 13, UNITY_GAIN = 13'd2048.
  - The state enum {IDLE, SCAN, COMMIT}.
  - The gain_t typedef.
- One sub-module, eq_gain_step_unit: combinational (current, target, STEP) -> next; this is the shared stepper.

Test Plan:
1. Reset, then release:
   - applied all 2048; gains_valid 0, busy 0, settled 0, tick_overrun 0.
   - No tick applied -> outputs unchanged for 100 cycles.
2. Band 3 target 2088, others 2048, STEP 16, enable = 1, ticks every 20 cycles:
   - Band 3 reads 2064, then 2080, then 2088.
   - Each update appears exactly 12 cycles after its tick, with a gains_valid pulse.
   - settled = 1 after the third commit.
3. Band 10 target 5 from 2048:
   - Decreases by 16 per tick: 2048 -> 2032 -> ... -> 16, then 5 on tick 128.
   - Never below 5; no wrap to 8191.
4. Tick at T, second tick at T+5:
   - tick_overrun pulses at T+6.
   - Exactly one gains_valid pulse, at T+12.
   - Applied gains reflect one step only.
5. Tick at T, band 1 target changed at T+3:
   - Commit at T+12 uses the old band 1 target.
   - The next tick steps toward the new value.
6. rst_n asserted at T+6 mid-SCAN:
   - Outputs return immediately to reset values.
   - After release, a tick yields a clean pass from 2048 with a normal T+12 timing.
